// File: rtl/multiplier_seq_if.sv
// multiplier_seq_if
//   Request/response bundle for the iterative multiplier.
//   start       : request; taken on an edge where start && ready
//   signed_mode : 0 = unsigned, 1 = two's-complement (sampled at accept)
//   A, B        : multiplicand / multiplier (sampled at accept)
//   ready       : high while the multiplier is idle
//   done        : one-cycle pulse when product is new
//   product     : 2*WIDTH-bit result, held until next completion or reset
interface multiplier_seq_if #(
  parameter int WIDTH = 64
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 ready;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  // Requester side drives operands and start, observes status and result
  modport master (
    output start, signed_mode, A, B,
    input  ready, done, product
  );

  // Multiplier side
  modport slave (
    input  start, signed_mode, A, B,
    output ready, done, product
  );
endinterface

// File: rtl/multiplier_seq.sv
// multiplier_seq
//   Iterative shift-and-add multiplier retiring STEP multiplier bits per
//   clock. Signed operation multiplies magnitudes and negates the result at
//   the end, so one unsigned datapath serves both modes.
//   Parameters : WIDTH (even, >= 4), STEP (1, 2 or 4, divides WIDTH)
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   bus        : multiplier_seq_if slave modport (start/ready handshake,
//                operands, done pulse, product)
//   Latency from accept edge to done is WIDTH/STEP + 1 cycles.
module multiplier_seq #(
  parameter int WIDTH = 64,
  parameter int STEP  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  multiplier_seq_if.slave   bus
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_accept;
  logic [WIDTH-1:0]     w_magA;
  logic [WIDTH-1:0]     w_magB;
  logic                 w_negA;
  logic                 w_negB;
  logic [2*WIDTH-1:0]   w_partial;

  // Signed inputs are reduced to magnitudes; the most negative value maps to
  // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
  always_comb begin
    w_negA   = bus.signed_mode & bus.A[WIDTH-1];
    w_negB   = bus.signed_mode & bus.B[WIDTH-1];
    w_magA   = w_negA ? ((~bus.A) + WIDTH'(1)) : bus.A;
    w_magB   = w_negB ? ((~bus.B) + WIDTH'(1)) : bus.B;
    w_accept = (r_state == IDLE) && bus.start;
  end

  // Partial product for the low STEP bits of the multiplier; r_mcand is
  // already aligned to the current shift position.
  always_comb begin
    w_partial = '0;
    for (int j = 0; j < STEP; j++) begin
      if (r_mplier[j]) begin
        w_partial = w_partial + (r_mcand << j);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: RUN lasts exactly N edges, counted down from N to 1
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = RUN;
      RUN:     if (r_cnt == CW'(1)) w_nextState = FIX;
      FIX:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: load on accept, accumulate in RUN, sign-fix and publish in FIX.
  // done is cleared every cycle it is not being raised, giving a 1-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_magA};
            r_mplier <= w_magB;
            r_neg    <= w_negA ^ w_negB;
            r_acc    <= '0;
            r_cnt    <= CNT_LOAD;
          end
        end
        RUN: begin
          r_acc    <= r_acc + w_partial;
          r_mcand  <= r_mcand << STEP;
          r_mplier <= r_mplier >> STEP;
          r_cnt    <= r_cnt - CW'(1);
        end
        FIX: begin
          // Negating zero yields zero, so 0 * negative stays 0
          r_product <= r_neg ? ((~r_acc) + (2*WIDTH)'(1)) : r_acc;
          r_done    <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready   = (r_state == IDLE);
  assign bus.done    = r_done;
  assign bus.product = r_product;

endmodule

// File: doc/multiplier_seq.md
# multiplier_seq

Parametrised iterative multiplier, the multi-cycle successor to the combinational multiplier_64. It accepts two WIDTH-bit operands through a start/ready handshake and computes a 2*WIDTH-bit product over WIDTH/STEP cycles, retiring STEP multiplier bits per cycle. A run-time mode selects unsigned or two's-complement signed operation. It is used wherever a full-width array multiplier is too large and a fixed, known latency is acceptable.

## Interface
- WIDTH, 64, operand width in bits; legal values are even and at least 4.
- STEP, 1, multiplier bits retired per cycle; legal values are 1, 2 and 4; WIDTH % STEP must be 0.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request; accepted on an edge where start && ready.
- signed_mode  input  1  0 = unsigned, 1 = two's-complement; sampled at accept.
- A  input  WIDTH  multiplicand; sampled at accept.
- B  input  WIDTH  multiplier; sampled at accept.
- ready  output  1  high only in IDLE.
- done  output  1  one-cycle pulse when the product is valid.
- product  output  2*WIDTH  result; holds until the next completion or reset.

## Operation
- States: IDLE, RUN and FIX. N = WIDTH/STEP.
- **Reset** (rst_n=0 at an edge): go to IDLE, product=0, done=0, ready=1, clear all internal registers. Reset overrides any operation in progress, and the partial result is discarded.
- **IDLE**
  - On start && ready: latch the operands.
  - Unsigned mode: use the raw operands.
  - Signed mode: take the magnitudes |A| and |B| as WIDTH-bit unsigned values (|-2^(WIDTH-1)| = 2^(WIDTH-1) fits) and record neg = A[MSB] ^ B[MSB].
  - Clear the accumulator, load cnt=N and go to RUN.
- **RUN**
  - Each edge adds (multiplicand * STEP low bits of the multiplier) into the 2*WIDTH-bit accumulator at the current shift.
  - Each edge also shifts the multiplier right by STEP and decrements cnt.
  - When cnt reaches 1 on an edge, go to FIX on that edge.
- **FIX**
  - product <= neg ? (~acc + 1) : acc, taken modulo 2^(2*WIDTH).
  - Assert done and go to IDLE.
- **Arithmetic rules**
  - The result is exact: unsigned gives A*B in [0, (2^WIDTH-1)^2]; signed gives the two's-complement product in 2*WIDTH bits. No overflow is possible.
  - A zero product is never negated, so signed 0 * negative gives 0.
- **start while busy**: start in RUN or FIX is ignored and has no side effects; A, B and signed_mode may change freely during that time.
- **done**: registered; high for exactly one cycle, namely the first IDLE cycle after FIX.
- **Back-to-back**: start asserted during the done cycle is accepted, because ready=1 in that cycle.
- **product**: changes only at the FIX edge or at reset.

## Timing
- Accept at edge E0. RUN occupies edges E1..EN. FIX is edge EN+1.
- done=1 and the new product are visible in the cycle after edge EN+1, so latency is N+1 cycles from the accept edge.
- WIDTH=64, STEP=1: accept to done is 65 cycles. STEP=4: 17 cycles.
- ready falls the cycle after the accept edge and returns high in the same cycle done rises.
- Throughput is one operation per N+1 cycles. There is no pipelining.
- There are no combinational paths from inputs to outputs. ready, done and product are all registered or state-decoded.

## Test plan
- **Reset values**
  - Hold rst_n=0 for 3 cycles -> ready=1, done=0, product=0.
  - Assert start while rst_n=0 -> no operation is started.
- **Basic unsigned** (WIDTH=64, STEP=1, signed_mode=0)
  - A=5, B=3 -> done exactly 65 cycles after accept with product=15.
  - A=51733, B=13978 -> product=723123874.
  - A=7182774998391928837, B=5200998393840909382 -> product=37357601229957062350350166813109648734.
- **Unsigned extreme**: A=B=2^64-1 -> product=0xFFFFFFFFFFFFFFFE_0000000000000001. Also A=40221, B=0 -> product=0.
- **Signed mode**
  - -1 * -1 -> product=1.
  - -3 * 5 -> product=2^128-15.
  - -2^63 * -1 -> product=0x0000000000000000_8000000000000000.
  - -2^63 * -2^63 -> product=2^126.
  - 0 * -7 -> product=0.
- **Handshake**
  - Assert start every cycle with changing operands -> only edges with ready=1 accept.
  - Result matches the operands latched at accept.
  - done pulses for one cycle per operation.
  - A back-to-back accept in the done cycle completes 65 cycles later.
- **Reset mid-operation and STEP variant**
  - Deassert rst_n at cycle 30 of a RUN -> IDLE next cycle, product=0, done never pulses.
  - Then run 121*255 -> product=30855.
  - Repeat the first four scenarios with STEP=4 (latency 17) and STEP=2 (latency 33) -> identical products.
